booth_mult_seq: RTL

//   Sequential, parametrised radix-4 Booth multiplier. Retires one Booth digit
//   (two multiplier bits) per clock through a single add/sub/shift datapath.

---
 rtl/booth_mult_seq_if.sv | 22 ++
 rtl/booth_mult_seq.sv | 120 ++++++++++++
 2 files changed

// File: rtl/booth_mult_seq_if.sv
// rtl/booth_mult_seq_if.sv - start/done handshake bundle for the sequential Booth multiplier
interface booth_mult_seq_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, signed_mode, mcand, mplier,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, mcand, mplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-4 Booth multiplier, one digit per clock
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  booth_mult_seq_if.slave bus
);
  // WIDTH/2 + 1 digits cover the WIDTH+2 bit extended multiplier, so the
  // same count gives an exact result for signed and unsigned operands.
  localparam int ITER = WIDTH / 2 + 1;
  localparam int CW   = $clog2(ITER + 1);
  localparam int AW   = WIDTH + 3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [WIDTH+1:0]     q_q, q_d;
  logic                 q1_q, q1_d;
  logic [WIDTH:0]       m_q, m_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [AW-1:0]        m_ext;
  logic [AW-1:0]        addend;
  logic [AW-1:0]        sum;
  logic [AW-1:0]        acc_sh;
  logic [WIDTH+1:0]     q_sh;
  logic                 q1_sh;
  logic                 ext_a;
  logic                 ext_b;

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

  // Booth digit selection, add, then 2-bit arithmetic shift of {ACC,Q,q_1}
  always_comb begin
    m_ext  = {{2{m_q[WIDTH]}}, m_q};
    addend = '0;
    case ({q_q[1:0], q1_q})
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m_ext << 1;
      3'b100:         addend = -(m_ext << 1);
      3'b101, 3'b110: addend = -m_ext;
      default:        addend = '0;
    endcase
    sum    = acc_q + addend;
    acc_sh = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_sh   = {sum[1:0], q_q[WIDTH+1:2]};
    q1_sh  = q_q[1];
  end

  // Next-state and register-load decisions; start is only honoured outside RUN
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    q_d       = q_q;
    q1_d      = q1_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    ext_a     = bus.signed_mode & bus.mcand[WIDTH-1];
    ext_b     = bus.signed_mode & bus.mplier[WIDTH-1];
    case (state_q)
      RUN: begin
        acc_d = acc_sh;
        q_d   = q_sh;
        q1_d  = q1_sh;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) begin
          state_d   = DONE;
          product_d = {acc_sh[WIDTH-3:0], q_sh};
        end
      end
      default: begin
        if (bus.start) begin
          state_d = RUN;
          m_d     = {ext_a, bus.mcand};
          q_d     = {{2{ext_b}}, bus.mplier};
          q1_d    = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // All state, datapath and registered outputs; reset aborts any operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      m_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end
endmodule
